// File: rtl/data_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_ram_ctrl_if
//  Purpose  : Request/response bundle between the decode stage and the data
//             RAM controller.
//  Signals  : ram_en          access request
//             ram_write_en    1 = store, 0 = load
//             ram_write_sel   byte-lane write enables (bit i -> data[8i+7:8i])
//             ram_addr        byte address
//             ram_write_data  lane-aligned store data
//             ram_read_data   load result word
//             ram_read_valid  one-cycle pulse qualifying ram_read_data
//             stall_req       pipeline hold while a load is in progress
//  Modports : master = requester (decode stage), slave = controller
//  Revision : 1.0  initial release
// ============================================================================
interface data_ram_ctrl_if;
  logic        ram_en;
  logic        ram_write_en;
  logic [3:0]  ram_write_sel;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        ram_read_valid;
  logic        stall_req;

  modport master (
    output ram_en, ram_write_en, ram_write_sel, ram_addr, ram_write_data,
    input  ram_read_data, ram_read_valid, stall_req
  );

  modport slave (
    input  ram_en, ram_write_en, ram_write_sel, ram_addr, ram_write_data,
    output ram_read_data, ram_read_valid, stall_req
  );
endinterface
`default_nettype wire

// File: rtl/data_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : data_ram_ctrl
//  Purpose  : DEPTH x 32 data memory with byte-lane stores (single cycle, no
//             stall) and two-cycle loads (stall in request and READ cycles,
//             valid pulse in DONE).
//  Ports    : clk  system clock, rising edge
//             rst  synchronous active-high reset (array contents preserved)
//             bus  data_ram_ctrl_if.slave request/response bundle
//  Params   : DEPTH  number of 32-bit words (power of two, 2 .. 2**29)
//  Revision : 1.0  initial release
// ============================================================================
module data_ram_ctrl #(
  parameter int DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst,
  data_ram_ctrl_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic [31:0]   read_data;
  logic          read_valid;
  logic          take_store;
  logic          take_load;

  // Byte offset and bits above the array size are ignored, so addresses
  // wrap modulo 4*DEPTH.
  assign req_idx = bus.ram_addr[AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ram_addr[31:AW+2], bus.ram_addr[1:0]};

  // Requests are only accepted in IDLE and never while reset is asserted;
  // anything presented in READ/DONE is dropped.
  assign take_store = !rst && (state == IDLE) && bus.ram_en &&  bus.ram_write_en;
  assign take_load  = !rst && (state == IDLE) && bus.ram_en && !bus.ram_write_en;

  // One byte-wide array per lane so each lane enable maps onto its own
  // write port; the array has no reset so contents survive rst.
  generate
    for (genvar i = 0; i < 4; i++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (take_store && bus.ram_write_sel[i]) begin
          lane_mem[req_idx] <= bus.ram_write_data[8*i +: 8];
        end
      end

      assign rd_word[8*i +: 8] = lane_mem[rd_idx];
    end
  endgenerate

  // Load sequencer: the index is captured in the request cycle, the word is
  // fetched at the end of READ, and the result is flagged valid in DONE.
  // A store in the request cycle's predecessor has already landed by then.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_idx     <= '0;
      read_data  <= 32'h0;
      read_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          read_valid <= 1'b0;
          if (take_load) begin
            rd_idx <= req_idx;
            state  <= READ;
          end
        end
        READ: begin
          read_data  <= rd_word;
          read_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          read_valid <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          read_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Stall must rise in the request cycle itself, so it is combinational on
  // the accepted load plus the registered READ state.
  assign bus.stall_req      = take_load || (state == READ);
  assign bus.ram_read_data  = read_data;
  assign bus.ram_read_valid = read_valid;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_ram_ctrl
//  Purpose  : Self-checking bench for data_ram_ctrl. Loads push their expected
//             word into a queue; a monitor pops and compares on every valid
//             pulse. Stall/valid timing is checked inline by the load task.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_ram_ctrl;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_ram_ctrl_if bus ();

  data_ram_ctrl #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (bus.ram_read_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {31'd0, bus.ram_read_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("read_data", bus.ram_read_data, e);
      end
    end
  end

  task automatic idle();
    bus.ram_en         = 1'b0;
    bus.ram_write_en   = 1'b0;
    bus.ram_write_sel  = 4'h0;
    bus.ram_addr       = 32'h0;
    bus.ram_write_data = 32'h0;
  endtask

  // Entered 1 time unit after a rising edge; leaves 1 unit after the next.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.ram_en         = 1'b1;
    bus.ram_write_en   = 1'b1;
    bus.ram_write_sel  = s;
    bus.ram_addr       = a;
    bus.ram_write_data = d;
    #3 check("store_stall", {31'd0, bus.stall_req}, 32'd0);
    @(posedge clk); #1;
    idle();
  endtask

  // busy_mode: 0 = drop request, 1 = keep load asserted, 2 = store all-ones
  // to the same address while the load is in flight.
  task automatic drive_busy(input int busy_mode, input logic [31:0] a);
    case (busy_mode)
      1: begin
        bus.ram_en = 1'b1; bus.ram_write_en = 1'b0; bus.ram_addr = a;
      end
      2: begin
        bus.ram_en = 1'b1; bus.ram_write_en = 1'b1; bus.ram_addr = a;
        bus.ram_write_sel = 4'hF; bus.ram_write_data = 32'hFFFF_FFFF;
      end
      default: idle();
    endcase
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [31:0] exp,
                      input int busy_mode);
    bus.ram_en       = 1'b1;
    bus.ram_write_en = 1'b0;
    bus.ram_addr     = a;
    exp_q.push_back(exp);
    #3;
    check({tag, "_stall_t0"}, {31'd0, bus.stall_req}, 32'd1);
    check({tag, "_valid_t0"}, {31'd0, bus.ram_read_valid}, 32'd0);
    @(posedge clk); #1;
    drive_busy(busy_mode, a);
    #3;
    check({tag, "_stall_t1"}, {31'd0, bus.stall_req}, 32'd1);
    check({tag, "_valid_t1"}, {31'd0, bus.ram_read_valid}, 32'd0);
    @(posedge clk); #1;
    drive_busy(busy_mode, a);
    #3;
    check({tag, "_stall_t2"}, {31'd0, bus.stall_req}, 32'd0);
    check({tag, "_valid_t2"}, {31'd0, bus.ram_read_valid}, 32'd1);
    @(posedge clk); #1;
    idle();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #4;
    check("rst_read_data",  bus.ram_read_data, 32'h0);
    check("rst_read_valid", {31'd0, bus.ram_read_valid}, 32'd0);
    check("rst_stall",      {31'd0, bus.stall_req}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full-word store then load in the very next cycle.
    store(32'h10, 32'hDEAD_BEEF, 4'hF);
    load("ld_10", 32'h10, 32'hDEAD_BEEF, 0);

    // Zero lane mask must not disturb the word; read data holds meanwhile.
    store(32'h10, 32'h0000_0000, 4'h0);
    store(32'h20, 32'h1122_3344, 4'hF);
    check("hold_data", bus.ram_read_data, 32'hDEAD_BEEF);
    load("ld_sel0", 32'h10, 32'hDEAD_BEEF, 0);

    // Partial lane write: lanes 0 and 2 replaced.
    store(32'h20, 32'hAABB_CCDD, 4'b0101);
    load("ld_lanes", 32'h20, 32'h11BB_33DD, 0);

    // Address wrap and ignored byte offset.
    store(32'h0, 32'h5A5A_5A5A, 4'hF);
    load("ld_wrap", 32'h1000, 32'h5A5A_5A5A, 0);
    load("ld_lowbits", 32'h13, 32'hDEAD_BEEF, 0);

    // Request held through READ/DONE: still a single read.
    load("ld_hold", 32'h20, 32'h11BB_33DD, 1);

    // Store presented during READ/DONE must be dropped.
    load("ld_busy_st", 32'h0, 32'h5A5A_5A5A, 2);
    load("ld_after_busy", 32'h0, 32'h5A5A_5A5A, 0);

    // Store under reset is ignored; reset leaves the array intact.
    store(32'h30, 32'h0102_0304, 4'hF);
    rst                = 1'b1;
    bus.ram_en         = 1'b1;
    bus.ram_write_en   = 1'b1;
    bus.ram_write_sel  = 4'hF;
    bus.ram_addr       = 32'h30;
    bus.ram_write_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    idle();
    rst = 1'b0;
    load("ld_rst_store", 32'h30, 32'h0102_0304, 0);

    // Reset during READ aborts the load without a valid pulse.
    bus.ram_en       = 1'b1;
    bus.ram_write_en = 1'b0;
    bus.ram_addr     = 32'h10;
    @(posedge clk); #1;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #3;
    check("abort_read_data", bus.ram_read_data, 32'h0);
    check("abort_stall",     {31'd0, bus.stall_req}, 32'd0);
    check("abort_valid",     {31'd0, bus.ram_read_valid}, 32'd0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;

    load("ld_after_rst", 32'h10, 32'hDEAD_BEEF, 0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
